vmul_operand_sequencer: RTL and testbench

- Multi-cycle successor to the fixed 8-slot byte splitter in the vector execution unit's multiplier.
- Takes NUM_LANES 32-bit operand word pairs per operation.
- Schedules every byte-by-byte partial product onto NUM_LANES*4 8-bit multiplier slots over 1, 2 or 4 beats (SEW 8/16/32).
- Tags each slot with shift, element and sign-position metadata for the downstream accumulator; valid/ready on both sides.

---
 rtl/vmul_pkg.sv | 33 +++
 rtl/vmul_operand_sequencer_if.sv | 37 +++
 rtl/vmul_slot_map.sv | 47 ++++
 rtl/vmul_operand_sequencer.sv | 164 ++++++++++++++++
 tb/tb_vmul_operand_sequencer.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/vmul_pkg.sv
// Shared types and helpers for the vector multiplier operand sequencer.
// Covers the element size encoding, the data widths and the per-slot tag record.
package vmul_pkg;

  typedef enum logic [1:0] {
    SEW8    = 2'b00,
    SEW16   = 2'b01,
    SEW32   = 2'b10,
    SEW_ILL = 2'b11
  } sew_e;

  localparam int BYTE_W  = 8;
  localparam int WORD_W  = 32;
  localparam int SHIFT_W = 3;

  typedef struct packed {
    logic [SHIFT_W-1:0] shift;
    logic [1:0]         elem;
    logic               a_top;
    logic               b_top;
  } slot_meta_t;

  // Beats per operation equals element size in bytes; an illegal SEW issues one error beat.
  function automatic logic [2:0] sew_beats(sew_e sew);
    case (sew)
      SEW8:    return 3'd1;
      SEW16:   return 3'd2;
      SEW32:   return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/vmul_operand_sequencer_if.sv
// Operand-in / slot-beat-out bus of the operand sequencer.
// The master is the operand source and beat consumer; the slave is the sequencer itself.
interface vmul_operand_sequencer_if #(parameter int NUM_LANES = 2);

  localparam int NUM_SLOTS = NUM_LANES * 4;

  logic                   in_valid;
  logic                   in_ready;
  logic [NUM_LANES*32-1:0] in_a;
  logic [NUM_LANES*32-1:0] in_b;
  logic [1:0]             in_sew;

  logic                   out_valid;
  logic                   out_ready;
  logic [NUM_SLOTS*8-1:0] out_a;
  logic [NUM_SLOTS*8-1:0] out_b;
  logic [NUM_SLOTS*3-1:0] out_shift;
  logic [NUM_SLOTS*2-1:0] out_elem;
  logic [NUM_SLOTS-1:0]   out_a_top;
  logic [NUM_SLOTS-1:0]   out_b_top;
  logic [1:0]             out_beat;
  logic                   out_last;
  logic                   out_err;

  modport master (
    output in_valid, in_a, in_b, in_sew, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_shift, out_elem,
           out_a_top, out_b_top, out_beat, out_last, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sew, out_ready,
    output in_ready, out_valid, out_a, out_b, out_shift, out_elem,
           out_a_top, out_b_top, out_beat, out_last, out_err
  );

endinterface

// File: rtl/vmul_slot_map.sv
// Maps (element size, beat, local slot) to the partial-product byte pair it computes.
// The same mapping serves every word, so one instance per local slot position suffices.
module vmul_slot_map
  import vmul_pkg::*;
(
  input  sew_e       i_sew,
  input  logic [1:0] i_beat,
  input  logic [1:0] i_m,
  output logic [1:0] o_i,
  output logic [1:0] o_j,
  output logic [1:0] o_e,
  output logic [1:0] o_a_idx,
  output logic [1:0] o_b_idx
);

  // With k in {1,2,4}, q/(k*k) and q%(k*k) reduce to bit slices of q = {beat, m}.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    o_i     = '0;
    o_j     = '0;
    o_e     = '0;
    o_a_idx = '0;
    o_b_idx = '0;
    case (i_sew)
      SEW8: begin
        o_e     = i_m;
        o_a_idx = i_m;
        o_b_idx = i_m;
      end
      SEW16: begin
        o_i     = {1'b0, i_m[1]};
        o_j     = {1'b0, i_m[0]};
        o_e     = {1'b0, i_beat[0]};
        o_a_idx = {i_beat[0], i_m[1]};
        o_b_idx = {i_beat[0], i_m[0]};
      end
      SEW32: begin
        o_i     = i_beat;
        o_j     = i_m;
        o_a_idx = i_beat;
        o_b_idx = i_m;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vmul_operand_sequencer.sv
// Splits NUM_LANES operand word pairs into byte partial products over 1, 2 or 4 beats,
// tagging each 8-bit multiplier slot with shift, element and sign-position metadata.
module vmul_operand_sequencer
  import vmul_pkg::*;
#(
  parameter int NUM_LANES = 2
) (
  input logic                     clk,
  input logic                     reset,
  vmul_operand_sequencer_if.slave bus
);

  localparam int NUM_SLOTS = NUM_LANES * 4;

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                    r_state, w_state_nxt;
  logic [1:0]                r_beat, w_beat_nxt;
  sew_e                      r_sew, w_sel_sew;
  logic [NUM_LANES*32-1:0]   r_a, r_b, w_sel_a, w_sel_b;
  logic                      w_accept, w_fire, w_load, w_valid_nxt;

  logic                      r_out_valid, r_out_last, r_out_err;
  logic [1:0]                r_out_beat;
  logic [NUM_SLOTS*8-1:0]    r_out_a, r_out_b, w_a_nxt, w_b_nxt;
  logic [NUM_SLOTS*3-1:0]    r_out_shift, w_shift_nxt;
  logic [NUM_SLOTS*2-1:0]    r_out_elem, w_elem_nxt;
  logic [NUM_SLOTS-1:0]      r_out_a_top, r_out_b_top, w_a_top_nxt, w_b_top_nxt;
  logic                      w_last_nxt;
  logic [1:0]                w_kmax;
  logic [1:0]                w_i [4];
  logic [1:0]                w_j [4];
  logic [1:0]                w_e [4];
  logic [1:0]                w_a_idx [4];
  logic [1:0]                w_b_idx [4];

  assign bus.in_ready = !reset && (!r_out_valid || (bus.out_ready && r_out_last));
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_fire       = r_out_valid && bus.out_ready;

  // A beat loaded in the accept cycle reads the incoming operands directly.
  assign w_sel_sew = w_accept ? sew_e'(bus.in_sew) : r_sew;
  assign w_sel_a   = w_accept ? bus.in_a : r_a;
  assign w_sel_b   = w_accept ? bus.in_b : r_b;

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_valid_nxt = r_out_valid;
    w_load      = 1'b0;
    if (w_accept) begin
      w_state_nxt = ISSUE;
      w_beat_nxt  = 2'd0;
      w_valid_nxt = 1'b1;
      w_load      = 1'b1;
    end else if (r_state == ISSUE && w_fire) begin
      if (r_out_last) begin
        w_state_nxt = IDLE;
        w_beat_nxt  = 2'd0;
        w_valid_nxt = 1'b0;
      end else begin
        w_beat_nxt  = r_beat + 2'd1;
        w_load      = 1'b1;
      end
    end
  end

  for (genvar m = 0; m < 4; m++) begin : g_map
    vmul_slot_map u_map (
      .i_sew   (w_sel_sew),
      .i_beat  (w_beat_nxt),
      .i_m     (2'(m)),
      .o_i     (w_i[m]),
      .o_j     (w_j[m]),
      .o_e     (w_e[m]),
      .o_a_idx (w_a_idx[m]),
      .o_b_idx (w_b_idx[m])
    );
  end

  assign w_kmax     = 2'(sew_beats(w_sel_sew) - 3'd1);
  assign w_last_nxt = ({1'b0, w_beat_nxt} == sew_beats(w_sel_sew) - 3'd1);

  always_comb begin
    slot_meta_t meta;
    w_a_nxt     = '0;
    w_b_nxt     = '0;
    w_shift_nxt = '0;
    w_elem_nxt  = '0;
    w_a_top_nxt = '0;
    w_b_top_nxt = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      meta = '0;
      if (w_sel_sew != SEW_ILL) begin
        w_a_nxt[BYTE_W*s +: BYTE_W] =
          w_sel_a[WORD_W*(s/4) + BYTE_W*int'(w_a_idx[s%4]) +: BYTE_W];
        w_b_nxt[BYTE_W*s +: BYTE_W] =
          w_sel_b[WORD_W*(s/4) + BYTE_W*int'(w_b_idx[s%4]) +: BYTE_W];
        meta.shift = SHIFT_W'(w_i[s%4]) + SHIFT_W'(w_j[s%4]);
        meta.elem  = w_e[s%4];
        meta.a_top = (w_i[s%4] == w_kmax);
        meta.b_top = (w_j[s%4] == w_kmax);
      end
      w_shift_nxt[SHIFT_W*s +: SHIFT_W] = meta.shift;
      w_elem_nxt[2*s +: 2]              = meta.elem;
      w_a_top_nxt[s]                    = meta.a_top;
      w_b_top_nxt[s]                    = meta.b_top;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state     <= IDLE;
      r_beat      <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_err   <= 1'b0;
      r_out_beat  <= '0;
      r_out_a     <= '0;
      r_out_b     <= '0;
      r_out_shift <= '0;
      r_out_elem  <= '0;
      r_out_a_top <= '0;
      r_out_b_top <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_beat      <= w_beat_nxt;
      r_out_valid <= w_valid_nxt;
      if (w_load) begin
        r_out_last  <= w_last_nxt;
        r_out_err   <= (w_sel_sew == SEW_ILL);
        r_out_beat  <= w_beat_nxt;
        r_out_a     <= w_a_nxt;
        r_out_b     <= w_b_nxt;
        r_out_shift <= w_shift_nxt;
        r_out_elem  <= w_elem_nxt;
        r_out_a_top <= w_a_top_nxt;
        r_out_b_top <= w_b_top_nxt;
      end
    end
  end

  // NOTE: operand registers need no reset; they are only read after an accept has loaded them.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_sew <= sew_e'(bus.in_sew);
      r_a   <= bus.in_a;
      r_b   <= bus.in_b;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.out_err   = r_out_err;
  assign bus.out_beat  = r_out_beat;
  assign bus.out_a     = r_out_a;
  assign bus.out_b     = r_out_b;
  assign bus.out_shift = r_out_shift;
  assign bus.out_elem  = r_out_elem;
  assign bus.out_a_top = r_out_a_top;
  assign bus.out_b_top = r_out_b_top;

endmodule

// File: tb/tb_vmul_operand_sequencer.sv
// Directed bench for the operand sequencer: fixed operand words, hand-computed slot values.
module tb_vmul_operand_sequencer;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  localparam logic [31:0] A0 = 32'h11223344;
  localparam logic [31:0] B0 = 32'hAABBCCDD;
  localparam logic [31:0] A1 = 32'h55667788;
  localparam logic [31:0] B1 = 32'h9900FF11;

  vmul_operand_sequencer_if #(.NUM_LANES(2)) bus ();

  vmul_operand_sequencer #(.NUM_LANES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one operation and returns one step after its accept edge (first beat visible).
  task automatic send(input logic [1:0] sew, input logic [63:0] a, input logic [63:0] b);
    int n;
    bus.in_valid = 1'b1;
    bus.in_sew   = sew;
    bus.in_a     = a;
    bus.in_b     = b;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) check("send_timeout", 64'd0, 64'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sew    = 2'b00;
    bus.out_ready = 1'b1;
    step();
    step();
    check("rst_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_a", bus.out_a, 0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);

    // 1: SEW8 single beat
    send(2'b00, {A1, A0}, {B1, B0});
    check("s8_valid", bus.out_valid, 1);
    check("s8_a", bus.out_a, 64'h55667788_11223344);
    check("s8_b", bus.out_b, 64'h9900FF11_AABBCCDD);
    check("s8_shift", bus.out_shift, 0);
    check("s8_elem", bus.out_elem, 16'hE4E4);
    check("s8_a_top", bus.out_a_top, 8'hFF);
    check("s8_b_top", bus.out_b_top, 8'hFF);
    check("s8_last", bus.out_last, 1);
    check("s8_err", bus.out_err, 0);
    step();
    check("s8_done", bus.out_valid, 0);

    // 2: SEW16 two beats
    send(2'b01, {A1, A0}, {B1, B0});
    check("s16_b0_beat", bus.out_beat, 0);
    check("s16_b0_a", bus.out_a, 64'h77778888_33334444);
    check("s16_b0_b", bus.out_b[31:0], 32'hCCDDCCDD);
    check("s16_b0_shift", bus.out_shift[11:0], 12'h448);
    check("s16_b0_elem", bus.out_elem, 0);
    check("s16_b0_a_top", bus.out_a_top, 8'hCC);
    check("s16_b0_b_top", bus.out_b_top, 8'hAA);
    check("s16_b0_last", bus.out_last, 0);
    step();
    check("s16_b1_beat", bus.out_beat, 1);
    check("s16_b1_a", bus.out_a[31:0], 32'h11112222);
    check("s16_b1_b", bus.out_b[31:0], 32'hAABBAABB);
    check("s16_b1_elem", bus.out_elem, 16'h5555);
    check("s16_b1_last", bus.out_last, 1);
    step();
    check("s16_done", bus.out_valid, 0);

    // 3: SEW32 with a 3-cycle stall on beat 2
    send(2'b10, {A1, A0}, {B1, B0});
    check("s32_b0_a", bus.out_a[31:0], 32'h44444444);
    check("s32_b0_b_top", bus.out_b_top, 8'h88);
    step();
    check("s32_b1_beat", bus.out_beat, 1);
    step();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("s32_stall_beat", bus.out_beat, 2);
      check("s32_stall_a", bus.out_a[31:0], 32'h22222222);
      check("s32_stall_b", bus.out_b[31:0], 32'hAABBCCDD);
      check("s32_stall_shift", bus.out_shift[11:0], 12'hB1A);
      check("s32_stall_in_ready", bus.in_ready, 0);
      step();
    end
    bus.out_ready = 1'b1;
    check("s32_b2_hold", bus.out_beat, 2);
    step();
    check("s32_b3_beat", bus.out_beat, 3);
    check("s32_b3_a", bus.out_a[31:0], 32'h11111111);
    check("s32_b3_shift", bus.out_shift[11:0], 12'hD63);
    check("s32_b3_a_top", bus.out_a_top, 8'hFF);
    check("s32_b3_last", bus.out_last, 1);
    step();
    check("s32_done", bus.out_valid, 0);

    // 4: back-to-back SEW8 operations, second with swapped operands
    send(2'b00, {A1, A0}, {B1, B0});
    bus.in_valid = 1'b1;
    bus.in_sew   = 2'b00;
    bus.in_a     = {B1, B0};
    bus.in_b     = {A1, A0};
    #1;
    check("b2b_in_ready", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    check("b2b_valid", bus.out_valid, 1);
    check("b2b_a", bus.out_a, 64'h9900FF11_AABBCCDD);
    check("b2b_last", bus.out_last, 1);
    step();
    check("b2b_done", bus.out_valid, 0);

    // 5: reset during SEW32 beat 1
    send(2'b10, {A1, A0}, {B1, B0});
    step();
    check("rst_mid_beat", bus.out_beat, 1);
    reset = 1'b1;
    #1;
    check("rst_mid_in_ready", bus.in_ready, 0);
    step();
    check("rst_mid_valid", bus.out_valid, 0);
    check("rst_mid_a", bus.out_a, 0);
    check("rst_mid_shift", bus.out_shift, 0);
    check("rst_mid_last", bus.out_last, 0);
    reset = 1'b0;
    #1;
    check("rst_mid_ready_after", bus.in_ready, 1);
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_mid_no_beats", bus.out_valid, 0);
    end

    // 6: illegal SEW, then a legal op
    send(2'b11, {A1, A0}, {B1, B0});
    check("ill_valid", bus.out_valid, 1);
    check("ill_err", bus.out_err, 1);
    check("ill_last", bus.out_last, 1);
    check("ill_a", bus.out_a, 0);
    check("ill_b", bus.out_b, 0);
    check("ill_a_top", bus.out_a_top, 0);
    step();
    check("ill_done", bus.out_valid, 0);
    send(2'b00, {A1, A0}, {B1, B0});
    check("after_ill_err", bus.out_err, 0);
    check("after_ill_a", bus.out_a, 64'h55667788_11223344);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
